// File: rtl/morse_game_sequencer.sv
// morse_game_sequencer
// Game-mode sequencer for the Morse escape room. Arbitrates the practice and
// level switches, tracks which levels are unlocked, counts decoded letters in
// the playable modes and enforces an optional per-level time limit. The page
// index for the VGA page mux is re-sampled only on pixel-tick edges, so
// display changes always land on a pixel boundary.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   pix_tick     VGA pixel-clock enable; gates page_sel updates
//   practice     practice-mode switch (highest priority request)
//   lvl_sw       level select switches (lowest set bit wins)
//   letter_valid one-cycle pulse per decoded letter
//   lvl_won      per-level win flags from the level displays
//   mode         0 START, 1 PRACTICE, 2 LEVEL, 3 DONE, 4 LOCKED, 5 TIMEOUT
//   cur_level    level bound to LEVEL/DONE/LOCKED/TIMEOUT
//   page_sel     display page: 0 start, 1 practice, 2+k level k,
//                NUM_LEVELS+2 done, +3 locked, +4 timeout
//   letter_count letters entered since the last PRACTICE/LEVEL entry
//   level_clear  one-cycle pulse during the first LEVEL cycle after entry
//   unlocked     unlock mask; bits are only ever set
module morse_game_sequencer #(
  parameter int NUM_LEVELS  = 3,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 0,
  parameter int UNLOCK_ALL  = 0,
  parameter int PAGE_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_tick,
  input  logic                  practice,
  input  logic [NUM_LEVELS-1:0] lvl_sw,
  input  logic                  letter_valid,
  input  logic [NUM_LEVELS-1:0] lvl_won,
  output logic [2:0]            mode,
  output logic [2:0]            cur_level,
  output logic [PAGE_W-1:0]     page_sel,
  output logic [CNT_W-1:0]      letter_count,
  output logic                  level_clear,
  output logic [NUM_LEVELS-1:0] unlocked
);

  typedef enum logic [2:0] {
    M_START    = 3'd0,
    M_PRACTICE = 3'd1,
    M_LEVEL    = 3'd2,
    M_DONE     = 3'd3,
    M_LOCKED   = 3'd4,
    M_TIMEOUT  = 3'd5
  } mode_e;

  // A zero-width timer is not legal, so keep at least one bit even when the
  // timeout is disabled or a single cycle long.
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LOAD = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mode_e           state;
  logic [TW-1:0]   timer;

  // The FSM state is the mode output itself, so checkers can bind to it.
  assign mode = state;

  // Request decode: practice first, else lowest set level switch, else none.
  logic                  req_lvl;
  logic [2:0]            req_idx;
  logic                  req_unlocked;
  logic                  bound;
  logic                  win;
  logic                  expire;
  logic [NUM_LEVELS-1:0] unlock_set;
  logic [PAGE_W-1:0]     page_nxt;

  always_comb begin
    req_lvl = 1'b0;
    req_idx = '0;
    // Descending scan so the lowest set bit is the last assignment.
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (lvl_sw[i]) begin
        req_lvl = 1'b1;
        req_idx = 3'(i);
      end
    end
  end

  // Per-level lookups written as loops to avoid narrow variable indexing.
  always_comb begin
    req_unlocked = 1'b0;
    win          = 1'b0;
    unlock_set   = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (req_idx == 3'(i) && unlocked[i]) req_unlocked = 1'b1;
      if (state == M_LEVEL && cur_level == 3'(i) && lvl_won[i]) win = 1'b1;
      // A win on level i-1 unlocks level i, even if the request is changing.
      if (i > 0 && state == M_LEVEL && cur_level == 3'(i - 1) && lvl_won[i - 1])
        unlock_set[i] = 1'b1;
    end
  end

  assign bound  = (state == M_LEVEL || state == M_DONE ||
                   state == M_LOCKED || state == M_TIMEOUT) && (cur_level == req_idx);
  assign expire = (TIMEOUT_CYC > 0) && (state == M_LEVEL) && (timer == '0);

  always_comb begin
    page_nxt = '0;
    case (state)
      M_START:    page_nxt = '0;
      M_PRACTICE: page_nxt = PAGE_W'(1);
      M_LEVEL:    page_nxt = PAGE_W'(cur_level) + PAGE_W'(2);
      M_DONE:     page_nxt = PAGE_W'(NUM_LEVELS + 2);
      M_LOCKED:   page_nxt = PAGE_W'(NUM_LEVELS + 3);
      M_TIMEOUT:  page_nxt = PAGE_W'(NUM_LEVELS + 4);
      default:    page_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= M_START;
      cur_level    <= '0;
      page_sel     <= '0;
      letter_count <= '0;
      level_clear  <= 1'b0;
      timer        <= '0;
      unlocked     <= {NUM_LEVELS{UNLOCK_ALL != 0}} | NUM_LEVELS'(1);
    end else begin
      level_clear <= 1'b0;
      unlocked    <= unlocked | unlock_set;
      if (pix_tick) page_sel <= page_nxt;

      // Defaults: count letters and run the timer in the current mode;
      // entries below override these with their clear/load values.
      if ((state == M_PRACTICE || state == M_LEVEL) && letter_valid &&
          letter_count != CNT_MAX)
        letter_count <= letter_count + 1'b1;
      if (state == M_LEVEL && timer != '0)
        timer <= timer - 1'b1;

      if (practice) begin
        if (state != M_PRACTICE) begin
          state        <= M_PRACTICE;
          letter_count <= '0;
        end
      end else if (!req_lvl) begin
        state <= M_START;
      end else if (!bound) begin
        cur_level <= req_idx;
        if (req_unlocked) begin
          state        <= M_LEVEL;
          letter_count <= '0;
          timer        <= T_LOAD;
          level_clear  <= 1'b1;
        end else begin
          state <= M_LOCKED;
        end
      end else if (state == M_LEVEL) begin
        // Win beats timeout when both happen in the same cycle.
        if (win)         state <= M_DONE;
        else if (expire) state <= M_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_morse_game_sequencer.sv
module tb_morse_game_sequencer;

  localparam int NL = 3;
  localparam int CW = 3;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pix_tick = 1'b0;
  logic          practice = 1'b0;
  logic [NL-1:0] lvl_sw = '0;
  logic          letter_valid = 1'b0;
  logic [NL-1:0] lvl_won = '0;
  logic [2:0]    mode;
  logic [2:0]    cur_level;
  logic [3:0]    page_sel;
  logic [CW-1:0] letter_count;
  logic          level_clear;
  logic [NL-1:0] unlocked;

  morse_game_sequencer #(
    .NUM_LEVELS(NL), .CNT_W(CW), .TIMEOUT_CYC(TO), .UNLOCK_ALL(0), .PAGE_W(4)
  ) dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .practice(practice),
    .lvl_sw(lvl_sw), .letter_valid(letter_valid), .lvl_won(lvl_won),
    .mode(mode), .cur_level(cur_level), .page_sel(page_sel),
    .letter_count(letter_count), .level_clear(level_clear), .unlocked(unlocked)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Modes as plain ints; the time limit is tracked by remembering the edge
  // number of the level entry rather than a countdown.
  int       edge_no = 0;
  int       m_mode, m_lvl, m_cnt, m_page, m_entry;
  bit       m_clear;
  bit [NL-1:0] m_unl;

  task automatic model_reset();
    m_mode = 0; m_lvl = 0; m_cnt = 0; m_page = 0; m_clear = 0; m_entry = 0;
    m_unl = 3'b001;
  endtask

  function automatic int page_of(input int md, input int lv);
    case (md)
      0: return 0;
      1: return 1;
      2: return 2 + lv;
      3: return NL + 2;
      4: return NL + 3;
      default: return NL + 4;
    endcase
  endfunction

  task automatic model_step();
    int req;             // -1 none, 99 practice, else level index
    bit win, expired;
    bit [NL-1:0] old_unl;
    req = -1;
    if (practice) req = 99;
    else for (int k = NL - 1; k >= 0; k--) if (lvl_sw[k]) req = k;
    old_unl = m_unl;
    if (pix_tick) m_page = page_of(m_mode, m_lvl);
    if ((m_mode == 1 || m_mode == 2) && letter_valid && m_cnt < (1 << CW) - 1) m_cnt++;
    win     = (m_mode == 2) && lvl_won[m_lvl];
    expired = (m_mode == 2) && (edge_no - m_entry >= TO);
    if (win && m_lvl + 1 < NL) m_unl[m_lvl + 1] = 1'b1;
    m_clear = 0;
    if (req == 99) begin
      if (m_mode != 1) begin m_mode = 1; m_cnt = 0; end
    end else if (req < 0) begin
      m_mode = 0;
    end else if (!(m_mode >= 2 && m_lvl == req)) begin
      m_lvl = req;
      if (old_unl[req]) begin
        m_mode = 2; m_cnt = 0; m_entry = edge_no; m_clear = 1;
      end else begin
        m_mode = 4;
      end
    end else if (m_mode == 2) begin
      if (win) m_mode = 3;
      else if (expired) m_mode = 5;
    end
  endtask

  always @(posedge clk) begin
    edge_no++;
    if (reset) model_step();
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    chk("mode", 32'(mode), 32'(m_mode));
    if (m_mode >= 2) chk("cur_level", 32'(cur_level), 32'(m_lvl));
    chk("page_sel", 32'(page_sel), 32'(m_page));
    chk("letter_count", 32'(letter_count), 32'(m_cnt));
    chk("level_clear", 32'(level_clear), 32'(m_clear));
    chk("unlocked", 32'(unlocked), 32'(m_unl));
  end

  // ---------------- driver ----------------
  bit pix_rand = 0;
  int pc = 0;

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      pc++;
      pix_tick = pix_rand ? ($urandom_range(0, 2) == 0) : (pc % 4 == 0);
    end
  endtask

  task automatic pulse_letter();
    letter_valid = 1'b1; cyc(1);
    letter_valid = 1'b0; cyc(1);
  endtask

  task automatic do_reset();
    #3 reset = 1'b0;
    model_reset();
    cyc(2);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    cyc(3);
    // Reset values while held.
    chk("rst_mode", 32'(mode), 0);
    chk("rst_page", 32'(page_sel), 0);
    chk("rst_cnt", 32'(letter_count), 0);
    chk("rst_clear", 32'(level_clear), 0);
    chk("rst_unl", 32'(unlocked), 32'b001);
    reset = 1'b1;
    cyc(2);

    // Practice with five letters, then back to start.
    practice = 1'b1; cyc(12);
    repeat (5) pulse_letter();
    cyc(4);
    chk("prac_mode", 32'(mode), 1);
    chk("prac_page", 32'(page_sel), 1);
    chk("prac_cnt", 32'(letter_count), 5);
    practice = 1'b0; cyc(6);
    chk("start_mode", 32'(mode), 0);
    chk("start_page", 32'(page_sel), 0);

    // Locked level, unlock by winning level 0, then enter level 1.
    lvl_sw = 3'b010; cyc(6);
    chk("lock_mode", 32'(mode), 4);
    chk("lock_lvl", 32'(cur_level), 1);
    chk("lock_page", 32'(page_sel), 6);
    lvl_sw = 3'b001; cyc(2);
    chk("l0_mode", 32'(mode), 2);
    lvl_won = 3'b001; cyc(1);
    lvl_won = 3'b000;
    chk("done_mode", 32'(mode), 3);
    chk("done_unl", 32'(unlocked), 32'b011);
    lvl_sw = 3'b010; cyc(1);
    chk("l1_mode", 32'(mode), 2);
    chk("l1_clear", 32'(level_clear), 1);
    cyc(1);
    chk("l1_clear_off", 32'(level_clear), 0);
    cyc(4);
    chk("l1_page", 32'(page_sel), 3);

    // Timeout exactly TO cycles after entry.
    lvl_sw = 3'b000; cyc(2);
    lvl_sw = 3'b001; cyc(1);
    cyc(TO - 1);
    chk("to_before", 32'(mode), 2);
    cyc(1);
    chk("to_mode", 32'(mode), 5);
    // Win and expiry on the same edge: win takes it.
    lvl_sw = 3'b000; cyc(1);
    lvl_sw = 3'b001; cyc(1);
    cyc(TO - 1);
    lvl_won = 3'b001; cyc(1);
    lvl_won = 3'b000;
    chk("win_vs_to", 32'(mode), 3);

    // Letter counter saturation, then clear on entry with a concurrent letter.
    lvl_sw = 3'b000; practice = 1'b1; cyc(2);
    repeat (9) pulse_letter();
    chk("sat_cnt", 32'(letter_count), 7);
    practice = 1'b0; lvl_sw = 3'b001; letter_valid = 1'b1; cyc(1);
    letter_valid = 1'b0;
    chk("entry_mode", 32'(mode), 2);
    chk("entry_cnt", 32'(letter_count), 0);

    // Practice beats level switches.
    lvl_sw = 3'b000; cyc(1);
    practice = 1'b1; lvl_sw = 3'b101; cyc(1);
    chk("prio_mode", 32'(mode), 1);
    practice = 1'b0; cyc(1);
    chk("prio_lvl_mode", 32'(mode), 2);
    chk("prio_lvl", 32'(cur_level), 0);

    // Asynchronous reset mid-LEVEL with no pixel tick.
    pix_tick = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_mode", 32'(mode), 0);
    chk("arst_lvl", 32'(cur_level), 0);
    chk("arst_page", 32'(page_sel), 0);
    chk("arst_cnt", 32'(letter_count), 0);
    chk("arst_clear", 32'(level_clear), 0);
    chk("arst_unl", 32'(unlocked), 32'b001);
    model_reset();
    cyc(2);
    lvl_sw = 3'b000;
    reset = 1'b1;
    cyc(2);

    // Randomized phase.
    pix_rand = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) practice = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) lvl_sw = 3'($urandom_range(0, 7));
      letter_valid = ($urandom_range(0, 2) == 0);
      lvl_won = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      if ($urandom_range(0, 799) == 0) do_reset();
      cyc(1);
    end
    letter_valid = 1'b0; lvl_won = '0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_game_sequencer.md
# morse_game_sequencer

Parametrised game-mode sequencer for the Morse escape-room design. It replaces the fixed three-level mode FSM. It arbitrates the practice and level switches, tracks per-level unlock progress, counts decoded letters and enforces a per-level time limit. It emits a pixel-tick-aligned page index that the VGA page multiplexer uses to select the active display. It sits between the Morse trie decoder, the level display modules and the VGA output mux.

## Interface
- NUM_LEVELS, 3, number of escape levels (1..8)
- CNT_W, 8, letter counter width
- TIMEOUT_CYC, 0, level time limit in clk cycles; 0 disables the timeout
- UNLOCK_ALL, 0, 1 = all levels unlocked from reset
- PAGE_W, 4, page index width (must hold NUM_LEVELS+4)
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- pix_tick  in  1  VGA pixel-clock enable pulse
- practice  in  1  practice-mode switch
- lvl_sw  in  NUM_LEVELS  level select switches
- letter_valid  in  1  one-cycle pulse per decoded letter
- lvl_won  in  NUM_LEVELS  win flag from each level display
- mode  out  3  0 START, 1 PRACTICE, 2 LEVEL, 3 DONE, 4 LOCKED, 5 TIMEOUT
- cur_level  out  3  active level index, valid in LEVEL/DONE/LOCKED/TIMEOUT
- page_sel  out  PAGE_W  display page: 0 start, 1 practice, 2+k level k, NUM_LEVELS+2 done, +3 locked, +4 timeout
- letter_count  out  CNT_W  letters entered in the current mode, saturating
- level_clear  out  1  one-cycle pulse on level entry; clears that level's display state
- unlocked  out  NUM_LEVELS  unlock mask

## Operation
- Request decode, combinational, every cycle:
  - practice has top priority.
  - Otherwise the lowest set lvl_sw bit k is the request.
  - Otherwise the request is none.
- Request none -> START from any state.
- Request practice -> PRACTICE from any state.
- Request level k, when the current state is not already bound to k:
  - unlocked[k]=1 -> LEVEL(k).
  - unlocked[k]=0 -> LOCKED(k).
- LEVEL(k):
  - lvl_won[k]=1 -> DONE(k); unlocked[k+1] is set (if k+1 < NUM_LEVELS).
  - Timer expiry -> TIMEOUT(k).
- DONE(k), LOCKED(k), TIMEOUT(k): held while the request stays k. Any other request leaves per the rules above.
- TIMEOUT(k) is re-armed only by leaving and re-requesting k.
- Request change has priority over win and timeout in the same cycle. The unlock from a concurrent win is still recorded.
- Win has priority over timeout in the same cycle.
- Entering PRACTICE or LEVEL clears letter_count to 0. Entry in the same cycle as letter_valid also yields 0.
- letter_count increments on letter_valid only in PRACTICE or LEVEL. It saturates at 2^CNT_W-1.
- The timer loads TIMEOUT_CYC-1 on level entry and decrements each cycle in LEVEL. Expiry is a zero value in LEVEL without a win.
- unlocked:
  - Reset value is 1 (bit 0 only), or all ones when UNLOCK_ALL=1.
  - Bits are only ever set; only reset clears them.
- Reset values, all asynchronous on reset low:
  - mode=0, cur_level=0, page_sel=0, letter_count=0, level_clear=0.
  - timer=0, unlocked as above.

## Timing
- mode, cur_level, letter_count, unlocked and level_clear are registered. They update at the first clk edge after the causing input.
- level_clear is high during exactly the first cycle in which mode=LEVEL after entry.
- TIMEOUT is entered exactly TIMEOUT_CYC cycles after the LEVEL entry edge.
- page_sel is derived from the registered mode/cur_level and loaded only on clk edges with pix_tick=1. Display changes therefore land on pixel boundaries.
- Latency from a switch change to page_sel is 1 cycle plus up to one pix_tick period.
- Reset deasserted mid-operation resumes from START. No pulse is emitted on reset release.

## Test plan
- Reset, practice=1 for 3 pix_ticks, then 5 letter_valid pulses -> mode=1, page_sel=1, letter_count=5. Switch off -> mode=0, page_sel=0.
- NUM_LEVELS=3: lvl_sw=3'b010 from reset -> mode=4, cur_level=1, page_sel=6. lvl_sw=3'b001, then lvl_won[0]=1 -> mode=3, unlocked=3'b011. lvl_sw=3'b010 -> mode=2, page_sel=3, level_clear pulses once.
- TIMEOUT_CYC=10: enter level 0, no win -> mode=5 exactly 10 cycles after entry. lvl_won[0] and expiry in the same cycle -> mode=3.
- CNT_W=3: 9 letter_valid pulses in PRACTICE -> letter_count=7. Switch to level 0 with a simultaneous letter_valid -> letter_count=0.
- practice=1 and lvl_sw=3'b101 together -> mode=1. Drop practice -> LEVEL(0).
- Assert reset low mid-LEVEL with pix_tick idle -> all outputs immediately at reset values, unlocked=3'b001.
